// File: rtl/invtlb_walker.sv
// INVTLB sequencer: walks every TLB entry once per request and
// clears the E bit of each valid entry selected by the op criteria.
module invtlb_walker #(
  parameter int TLB_NUM = 16,
  parameter int IDX_W   = 4,
  parameter int ASID_W  = 10,
  parameter int VPPN_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inv_valid,
  output logic              inv_ready,
  input  logic [4:0]        inv_op,
  input  logic [ASID_W-1:0] inv_asid,
  input  logic [VPPN_W-1:0] inv_vppn,
  output logic              busy,
  output logic              done,
  output logic              illegal_op,
  output logic [IDX_W-1:0]  tlb_rd_idx,
  input  logic              tlb_e,
  input  logic              tlb_g,
  input  logic [ASID_W-1:0] tlb_asid,
  input  logic [VPPN_W-1:0] tlb_vppn,
  input  logic              tlb_ps21,
  output logic              tlb_clr_en,
  output logic [IDX_W-1:0]  tlb_clr_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WALK,
    S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_NUM - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4:0]          op_q, op_d;
  logic [ASID_W-1:0]   asid_q, asid_d;
  logic [VPPN_W-1:0]   vppn_q, vppn_d;
  logic                illegal_q, illegal_d;

  logic                op_legal;
  logic                walking;
  logic                asid_hit;
  logic                va_hit;
  logic                match;

  assign op_legal = (inv_op <= 5'd6);
  assign walking  = (state_q == S_WALK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      op_q      <= '0;
      asid_q    <= '0;
      vppn_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      asid_q    <= asid_d;
      vppn_q    <= vppn_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    asid_d    = asid_q;
    vppn_d    = vppn_q;
    illegal_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (inv_valid) begin
          if (op_legal) begin
            state_d = S_WALK;
            idx_d   = '0;
            op_d    = inv_op;
            asid_d  = inv_asid;
            vppn_d  = inv_vppn;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_WALK: begin
        // Last entry wraps idx to 0, leaving it parked for the next walk
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Large pages ignore the low 9 VPPN bits
  always_comb begin
    asid_hit = (tlb_asid == asid_q);
    if (tlb_ps21) begin
      va_hit = (tlb_vppn[VPPN_W-1:9] == vppn_q[VPPN_W-1:9]);
    end else begin
      va_hit = (tlb_vppn == vppn_q);
    end
  end

  always_comb begin
    match = 1'b0;
    unique case (1'b1)
      (op_q == 5'd0),
      (op_q == 5'd1): match = 1'b1;
      (op_q == 5'd2): match = tlb_g;
      (op_q == 5'd3): match = ~tlb_g;
      (op_q == 5'd4): match = ~tlb_g & asid_hit;
      (op_q == 5'd5): match = ~tlb_g & asid_hit & va_hit;
      (op_q == 5'd6): match = (tlb_g | asid_hit) & va_hit;
      default:        match = 1'b0;
    endcase
  end

  assign inv_ready   = (state_q == S_IDLE);
  assign busy        = walking;
  assign done        = (state_q == S_DONE);
  assign illegal_op  = illegal_q;
  assign tlb_rd_idx  = idx_q;
  // A reset edge must never coincide with a clear
  assign tlb_clr_en  = walking & tlb_e & match & ~rst;
  assign tlb_clr_idx = idx_q;

endmodule

// File: tb/tb_invtlb_walker.sv
// Directed bench for invtlb_walker with a small TLB array model.
// Expected clear masks are hand-computed per scenario.
module tb_invtlb_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        inv_valid;
  logic        inv_ready;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic        busy;
  logic        done;
  logic        illegal_op;
  logic [3:0]  tlb_rd_idx;
  logic        tlb_e;
  logic        tlb_g;
  logic [9:0]  tlb_asid;
  logic [18:0] tlb_vppn;
  logic        tlb_ps21;
  logic        tlb_clr_en;
  logic [3:0]  tlb_clr_idx;

  logic        m_e    [16];
  logic        m_g    [16];
  logic [9:0]  m_asid [16];
  logic [18:0] m_vppn [16];
  logic        m_ps   [16];

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] clr_mask;
  int          n_clr;
  int          done_cyc;
  int          ready_cyc;
  int          busy_cnt;
  logic        seq_ok;

  always #5 clk = ~clk;

  invtlb_walker dut (
    .clk        (clk),
    .rst        (rst),
    .inv_valid  (inv_valid),
    .inv_ready  (inv_ready),
    .inv_op     (inv_op),
    .inv_asid   (inv_asid),
    .inv_vppn   (inv_vppn),
    .busy       (busy),
    .done       (done),
    .illegal_op (illegal_op),
    .tlb_rd_idx (tlb_rd_idx),
    .tlb_e      (tlb_e),
    .tlb_g      (tlb_g),
    .tlb_asid   (tlb_asid),
    .tlb_vppn   (tlb_vppn),
    .tlb_ps21   (tlb_ps21),
    .tlb_clr_en (tlb_clr_en),
    .tlb_clr_idx(tlb_clr_idx)
  );

  assign tlb_e    = m_e[tlb_rd_idx];
  assign tlb_g    = m_g[tlb_rd_idx];
  assign tlb_asid = m_asid[tlb_rd_idx];
  assign tlb_vppn = m_vppn[tlb_rd_idx];
  assign tlb_ps21 = m_ps[tlb_rd_idx];

  always @(posedge clk) begin
    if (tlb_clr_en) m_e[tlb_clr_idx] <= 1'b0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tlb_clear();
    for (int i = 0; i < 16; i++) begin
      m_e[i]    = 1'b0;
      m_g[i]    = 1'b0;
      m_asid[i] = '0;
      m_vppn[i] = '0;
      m_ps[i]   = 1'b0;
    end
  endtask

  task automatic tlb_set(input int i, input logic e, input logic g,
                         input logic [9:0] a, input logic [18:0] v,
                         input logic ps);
    m_e[i]    = e;
    m_g[i]    = g;
    m_asid[i] = a;
    m_vppn[i] = v;
    m_ps[i]   = ps;
  endtask

  // Issue one request and observe 24 cycles after the accept edge
  task automatic do_inv(input logic [4:0] op, input logic [9:0] a,
                        input logic [18:0] v);
    @(negedge clk);
    inv_valid = 1'b1;
    inv_op    = op;
    inv_asid  = a;
    inv_vppn  = v;
    @(posedge clk);
    #1;
    inv_valid = 1'b0;
    clr_mask  = '0;
    n_clr     = 0;
    done_cyc  = 0;
    ready_cyc = 0;
    busy_cnt  = 0;
    seq_ok    = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (tlb_clr_en) begin
        clr_mask[tlb_clr_idx] = 1'b1;
        n_clr++;
        if (int'(tlb_clr_idx) != c - 1) seq_ok = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done && done_cyc == 0) done_cyc = c;
      if (inv_ready && ready_cyc == 0) ready_cyc = c;
    end
  endtask

  initial begin
    rst       = 1'b1;
    inv_valid = 1'b0;
    inv_op    = '0;
    inv_asid  = '0;
    inv_vppn  = '0;
    tlb_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(inv_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ill", 32'(illegal_op), 32'd0);
    chk("rst_rdidx", 32'(tlb_rd_idx), 32'd0);
    chk("rst_clren", 32'(tlb_clr_en), 32'd0);
    chk("rst_clridx", 32'(tlb_clr_idx), 32'd0);

    // op 0, all entries valid
    for (int i = 0; i < 16; i++) tlb_set(i, 1, i[0], 10'(i), 19'(i), 0);
    do_inv(5'd0, 10'h0, 19'h0);
    chk("op0_mask", 32'(clr_mask), 32'hFFFF);
    chk("op0_nclr", 32'(n_clr), 32'd16);
    chk("op0_seq", 32'(seq_ok), 32'd1);
    chk("op0_done", 32'(done_cyc), 32'd17);
    chk("op0_ready", 32'(ready_cyc), 32'd18);
    chk("op0_busy", 32'(busy_cnt), 32'd16);

    // op 4, ASID filter on non-global entries
    tlb_clear();
    tlb_set(3, 1, 0, 10'h005, 19'h1, 0);
    tlb_set(7, 1, 1, 10'h005, 19'h2, 0);
    tlb_set(9, 1, 0, 10'h006, 19'h3, 0);
    do_inv(5'd4, 10'h005, 19'h0);
    chk("op4_mask", 32'(clr_mask), 32'h0008);

    // op 5 vs op 6, including large-page and small-page VA
    for (int pass = 0; pass < 2; pass++) begin
      tlb_clear();
      tlb_set(2, 1, 0, 10'h002, 19'h12345, 0);
      tlb_set(5, 1, 1, 10'h3FF, 19'h12345, 0);
      tlb_set(8, 1, 0, 10'h002, 19'h123FF, 1);
      tlb_set(10, 1, 0, 10'h002, 19'h123FF, 0);
      if (pass == 0) begin
        do_inv(5'd5, 10'h002, 19'h12345);
        chk("op5_mask", 32'(clr_mask), 32'h0104);
      end else begin
        do_inv(5'd6, 10'h002, 19'h12345);
        chk("op6_mask", 32'(clr_mask), 32'h0124);
      end
    end

    // op 2 / op 3, invalid global entry ignored
    for (int pass = 0; pass < 2; pass++) begin
      tlb_clear();
      tlb_set(1, 1, 0, 10'h001, 19'h1, 0);
      tlb_set(4, 0, 1, 10'h004, 19'h4, 0);
      tlb_set(6, 1, 1, 10'h006, 19'h6, 0);
      if (pass == 0) begin
        do_inv(5'd2, 10'h0, 19'h0);
        chk("op2_mask", 32'(clr_mask), 32'h0040);
      end else begin
        do_inv(5'd3, 10'h0, 19'h0);
        chk("op3_mask", 32'(clr_mask), 32'h0002);
      end
    end

    // illegal ops
    for (int i = 0; i < 16; i++) tlb_set(i, 1, 0, 10'h0, 19'h0, 0);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      inv_valid = 1'b1;
      inv_op    = (pass == 0) ? 5'd7 : 5'd31;
      @(posedge clk);
      #1;
      inv_valid = 1'b0;
      @(negedge clk);
      chk("ill_pulse", 32'(illegal_op), 32'd1);
      chk("ill_busy", 32'(busy), 32'd0);
      chk("ill_ready", 32'(inv_ready), 32'd1);
      chk("ill_clren", 32'(tlb_clr_en), 32'd0);
      @(negedge clk);
      chk("ill_end", 32'(illegal_op), 32'd0);
      chk("ill_busy2", 32'(busy), 32'd0);
    end

    // reset mid-walk at idx 5
    @(negedge clk);
    inv_valid = 1'b1;
    inv_op    = 5'd0;
    @(posedge clk);
    #1;
    inv_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (tlb_rd_idx == 4'd5) break;
    end
    chk("mid_idx", 32'(tlb_rd_idx), 32'd5);
    rst = 1'b1;
    #1;
    chk("mid_clr_rst", 32'(tlb_clr_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_clr    = 0;
    done_cyc = 0;
    busy_cnt = 0;
    seq_ok   = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (tlb_clr_en) n_clr++;
      if (done) done_cyc = c;
      if (busy) busy_cnt++;
      if (!inv_ready || tlb_rd_idx != 4'd0) seq_ok = 1'b0;
    end
    chk("mid_nclr", 32'(n_clr), 32'd0);
    chk("mid_done", 32'(done_cyc), 32'd0);
    chk("mid_busy", 32'(busy_cnt), 32'd0);
    chk("mid_idle", 32'(seq_ok), 32'd1);
    chk("mid_e5", 32'(m_e[5]), 32'd1);
    chk("mid_e4", 32'(m_e[4]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/invtlb_walker.md
Name: invtlb_walker

Overview:
- Sequencer that executes the INVTLB instruction against the TLB. It walks every TLB entry, one entry per cycle.
- Each entry is compared against the op-selected criteria. The operand ASID comes from rj[9:0] or from the ASID CSR field. The operand VA comes from rk.
- Matching valid entries have their E bit cleared through the TLB write port.
- Sits between the CSR/execute stage (consumer of the current ASID value) and the TLB array.

Parameters:
- TLB_NUM, 16, number of TLB entries; power of two, minimum 4.
- IDX_W, 4, log2(TLB_NUM).
- ASID_W, 10, ASID width.
- VPPN_W, 19, VPPN width (VA[31:13]).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inv_valid  in  1  INVTLB request
- inv_ready  out  1  walker idle, can accept
- inv_op  in  5  INVTLB op code
- inv_asid  in  ASID_W  operand ASID
- inv_vppn  in  VPPN_W  operand VA[31:13]
- busy  out  1  walk in progress
- done  out  1  one-cycle completion pulse
- illegal_op  out  1  one-cycle pulse, op not in 0..6 (INE)
- tlb_rd_idx  out  IDX_W  entry index being examined
- tlb_e  in  1  E bit of indexed entry (combinational read, same cycle)
- tlb_g  in  1  G bit of indexed entry
- tlb_asid  in  ASID_W  ASID of indexed entry
- tlb_vppn  in  VPPN_W  VPPN of indexed entry
- tlb_ps21  in  1  entry PS==21 (large page)
- tlb_clr_en  out  1  clear E of entry tlb_clr_idx at this clk edge
- tlb_clr_idx  out  IDX_W  entry to clear

Behaviour:
- Reset values: inv_ready=1, busy=0, done=0, illegal_op=0, tlb_rd_idx=0, tlb_clr_en=0, tlb_clr_idx=0. Any state forced to IDLE.
- States: IDLE, WALK, DONE.
- IDLE:
  - inv_ready=1.
  - Accept on inv_valid when the op is legal (0..6): latch op/asid/vppn, idx<=0, go to WALK.
  - Illegal op (7..31): illegal_op=1 in the next cycle. No walk, no clears. Stay IDLE with inv_ready=1.
- WALK:
  - inv_ready=0, busy=1, tlb_rd_idx=idx. Inputs during WALK are ignored.
  - Each cycle, match is computed combinationally from the latched operands and tlb_* inputs.
  - tlb_clr_en = tlb_e & match, with tlb_clr_idx=idx, in the same cycle.
  - idx increments each cycle. On idx==TLB_NUM-1, go to DONE; idx must not wrap back into WALK.
- DONE: done=1 for exactly one cycle, busy=0. Go to IDLE; inv_ready=1 in the following cycle.
- Latency: the accept edge is followed by TLB_NUM WALK cycles, then 1 DONE cycle. A new request is accepted TLB_NUM+2 cycles after the previous accept at the earliest.
- VA match:
  - tlb_ps21=1: compare vppn[VPPN_W-1:9] only.
  - Otherwise: compare the full VPPN_W bits.
- ASID match: full ASID_W equality.
- Match by op:
  - 0, 1: all entries.
  - 2: g=1.
  - 3: g=0.
  - 4: g=0 & ASID match.
  - 5: g=0 & ASID match & VA match.
  - 6: (g=1 | ASID match) & VA match.
- Entries with tlb_e=0 never generate tlb_clr_en.
- Concurrent TLB writes from TLBWR/TLBFILL are excluded upstream: the pipeline stalls while busy=1.
- rst asserted mid-walk: the next edge returns to IDLE with all outputs at reset values. No clears occur at or after that edge. The walk is not resumed.
- inv_valid held high through DONE: not re-accepted until the IDLE cycle. The request must be dropped by upstream after accept.

Test Plan:
- Op 0, all 16 entries e=1 -> tlb_clr_en high for 16 consecutive cycles with tlb_clr_idx 0..15; done pulses in cycle 17 after accept; inv_ready returns 1 one cycle later.
- Op 4, asid=0x005; entries 3 (g=0, asid 0x005), 7 (g=1, asid 0x005), 9 (g=0, asid 0x006) -> only idx 3 cleared.
- Op 5 vs op 6, asid=0x002, vppn=0x12345; entry 2 (g=0, asid 0x002, vppn 0x12345); entry 5 (g=1, asid 0x3FF, vppn 0x12345); entry 8 (ps21=1, g=0, asid 0x002, vppn 0x123FF) -> op 5 clears {2, 8}; op 6 clears {2, 5, 8}.
- Op 2 with entry 4 g=1 but e=0, entry 6 g=1 e=1 -> only idx 6 cleared.
- inv_op=7 with inv_valid=1 -> illegal_op=1 for one cycle; busy stays 0; no tlb_clr_en; inv_ready stays 1.
- Op 0 accepted, rst asserted at WALK idx=5 -> no tlb_clr_en from the reset edge onward, done never pulses, inv_ready=1, tlb_rd_idx=0.
